// File: rtl/otter_uart_pkg.sv
// Shared constants and state encodings for the OTTER IOBUS UART.
package otter_uart_pkg;

    localparam logic [3:0] TXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] RXDATA_OFS = 4'h8;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_TX_BUSY    = 2;
    localparam int ST_RX_VALID   = 3;
    localparam int ST_RX_OVERRUN = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; extra pointer bit tells full from empty.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [PW:0] wp_q, rp_q;
    logic        do_push, do_pop;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees a slot this cycle, so a push while full still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rp_q[PW-1:0]];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wp_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/otter_iobus_uart.sv
// IOBUS-mapped 8N1 UART: TX FIFO + TX FSM, optional RX path under OTTER_UART_RX_EN.
module otter_iobus_uart
    import otter_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          TX_DEPTH     = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        UART_TX,
    input  logic        UART_RX
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    logic [3:0]  ofs;
    logic        hit, wr_tx, wr_status, wr_rx;
    logic [31:0] status, rd_d, iobus_in_q;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic        rx_valid, rx_overrun;
    logic [7:0]  rx_byte;

    assign ofs       = IOBUS_ADDR[3:0];
    assign hit       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]) && (ofs <= 4'h8);
    assign wr_tx     = IOBUS_WR && hit && (ofs == TXDATA_OFS);
    assign wr_status = IOBUS_WR && hit && (ofs == STATUS_OFS);
    assign wr_rx     = IOBUS_WR && hit && (ofs == RXDATA_OFS);

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
        .CLK(CLK), .RESET(RESET), .push(wr_tx), .pop(fifo_pop),
        .din(IOBUS_OUT[7:0]), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
    );

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
        tx_sh_q <= tx_sh_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_sh_d    = fifo_dout;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = tx_sh_q[0];
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
                    tx_d       = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_d     = tx_sh_q[1];
                end
            end
            TX_STOP: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                // Chain straight into the next start bit so frames have no idle gap.
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_sh_d    = fifo_dout;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign UART_TX = tx_q;

`ifdef OTTER_UART_RX_EN
    rx_state_t     rx_state_q, rx_state_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_s1_q    <= UART_RX;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
        rx_sh_q <= rx_sh_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_bit_d   = rx_bit_q + 1'b1;
            end
            RX_STOP: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_done    = rx_s2_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        if (wr_rx)                     rx_valid_d = 1'b0;
        if (wr_status && IOBUS_OUT[4]) rx_ovr_d   = 1'b0;
        // Completion overrides a same-cycle pop or overrun clear.
        if (rx_done) begin
            rx_byte_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !wr_rx) rx_ovr_d = 1'b1;
        end
    end

    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_ovr_q;
    assign rx_byte    = rx_byte_q;
`else
    logic unused_rx;
    assign unused_rx  = ^{UART_RX, wr_rx, wr_status};
    assign rx_valid   = 1'b0;
    assign rx_overrun = 1'b0;
    assign rx_byte    = 8'h00;
`endif

    logic unused_hi;
    assign unused_hi = ^IOBUS_OUT[31:8];

    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = fifo_full;
        status[ST_TX_EMPTY]   = fifo_empty && (tx_state_q == TX_IDLE);
        status[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);
        status[ST_RX_VALID]   = rx_valid;
        status[ST_RX_OVERRUN] = rx_overrun;
        rd_d = '0;
        if (hit) begin
            case (ofs)
                STATUS_OFS: rd_d = status;
                RXDATA_OFS: rd_d = {24'b0, rx_byte};
                default:    rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) iobus_in_q <= '0;
        else       iobus_in_q <= rd_d;
    end

    assign IOBUS_IN = iobus_in_q;

endmodule

// File: tb/tb_otter_iobus_uart.sv
// Scoreboard bench for otter_iobus_uart: expected TX bytes queued on write, checked by a line monitor.
module tb_otter_iobus_uart;
    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
    logic        IOBUS_WR, UART_TX, UART_RX;

    int         total = 0, bad = 0, cyc = 0, frames = 0;
    logic [7:0] sb[$];
    int         starts[$];
    bit         mon_abort = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    otter_iobus_uart #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .UART_TX(UART_TX), .UART_RX(UART_RX)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK); IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
        @(negedge CLK); IOBUS_WR = 1'b0; IOBUS_ADDR = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge CLK); IOBUS_ADDR = a; IOBUS_WR = 1'b0;
        @(posedge CLK); #1; d = IOBUS_IN;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic rx_send(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK); UART_RX = f[i];
            repeat (CPB - 1) @(negedge CLK);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames < n && k < budget) begin
            @(posedge CLK);
            k++;
        end
        if (frames < n) chk("frame_timeout", frames, n);
    endtask

    // Line monitor: each frame start pops the scoreboard and every bit cycle is checked.
    initial begin : tx_mon
        logic [9:0] fb;
        logic [7:0] e;
        forever begin
            @(posedge CLK); #1;
            if (!mon_abort && UART_TX === 1'b0) begin
                starts.push_back(cyc);
                chk("tx_expected_frame", {31'b0, sb.size() != 0}, 32'd1);
                e  = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                fb = {1'b1, e, 1'b0};
                for (int i = 0; i < 10 * CPB; i++) begin
                    if (i > 0) begin @(posedge CLK); #1; end
                    if (mon_abort) break;
                    chk("tx_bit", {31'b0, UART_TX}, {31'b0, fb[i / CPB]});
                end
                if (!mon_abort) frames++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] v;
        int f0;
        RESET = 1'b1; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0; UART_RX = 1'b1;
        repeat (3) @(negedge CLK);
        @(posedge CLK); #1;
        chk("rst_iobus_in", IOBUS_IN, 32'h0);
        chk("rst_uart_tx", {31'b0, UART_TX}, 32'd1);
        @(negedge CLK); RESET = 1'b0;
        rd(BASE + 4, v); chk("rst_status", v, 32'h02);

        // single frame
        sb.push_back(8'h55);
        wr(BASE, 32'h55);
        idle(6);
        rd(BASE + 4, v); chk("t1_busy_status", v, 32'h04);
        wait_frames(1, 200);
        idle(2);
        rd(BASE + 4, v); chk("t1_status_after", v, 32'h02);

        // burst past FIFO capacity
        starts.delete();
        for (int i = 0; i < 5; i++) sb.push_back(8'(8'hA0 + i));
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); IOBUS_ADDR = BASE; IOBUS_OUT = 32'hA0 + i; IOBUS_WR = 1'b1;
        end
        @(negedge CLK); IOBUS_WR = 1'b0; IOBUS_ADDR = BASE + 4;
        @(posedge CLK); #1; chk("t2_full_status", IOBUS_IN, 32'h05);
        wait_frames(6, 400);
        idle(60);
        chk("t2_frames", frames, 6);
        chk("t2_starts", starts.size(), 5);
        if (starts.size() == 5) chk("t2_no_gap", starts[4] - starts[0], 4 * 10 * CPB);

        // reset mid-frame with bytes queued
        sb.push_back(8'hFF);
        wr(BASE, 32'hFF); wr(BASE, 32'h81); wr(BASE, 32'h42);
        idle(14);
        @(negedge CLK); IOBUS_ADDR = BASE + 4; mon_abort = 1'b1; RESET = 1'b1;
        @(posedge CLK); #1;
        chk("t5_tx_after_rst", {31'b0, UART_TX}, 32'd1);
        chk("t5_iobus_in_rst", IOBUS_IN, 32'h0);
        @(negedge CLK); RESET = 1'b0; sb.delete();
        rd(BASE + 4, v); chk("t5_status", v, 32'h02);
        f0 = frames;
        mon_abort = 1'b0;
        idle(100);
        chk("t5_no_frames", frames, f0);

        // unmapped and miss reads
        rd(BASE + 4, v);
        rd(32'h1100_0200, v); chk("t6_miss", v, 32'h0);
        rd(BASE + 4, v);
        rd(32'h1100_010C, v); chk("t6_ofs_c", v, 32'h0);
        rd(BASE + 4, v);
        rd(BASE, v); chk("t6_txdata_rd", v, 32'h0);

`ifdef OTTER_UART_RX_EN
        rx_send(8'h3C); idle(6);
        rd(BASE + 4, v); chk("t3_status", v, 32'h0A);
        rd(BASE + 8, v); chk("t3_rxdata", v, 32'h3C);
        wr(BASE + 8, 32'h0);
        rd(BASE + 4, v); chk("t3_pop", v, 32'h02);

        rx_send(8'h11); idle(6);
        rx_send(8'h22); idle(6);
        rd(BASE + 8, v); chk("t4_rxdata", v, 32'h22);
        rd(BASE + 4, v); chk("t4_rx_flags", v & 32'h18, 32'h18);
        wr(BASE + 4, 32'h10);
        rd(BASE + 4, v); chk("t4_ovr_clear", v & 32'h18, 32'h08);
        wr(BASE + 8, 32'h0);

        @(negedge CLK); UART_RX = 1'b0;
        repeat (2) @(negedge CLK);
        UART_RX = 1'b1;
        idle(20);
        rd(BASE + 4, v); chk("t6_glitch", v, 32'h02);
`else
        rx_send(8'h3C); idle(6);
        rd(BASE + 4, v); chk("norx_status", v, 32'h02);
        rd(BASE + 8, v); chk("norx_rxdata", v, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
